vec_intmul: RTL
===============

VEC_INTMUL -- requirements
Module: vec_intmul

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the operand width per lane in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of independent multiplier lanes.
REQ-003 The block SHALL have parameter ACC_GUARD, default 4, giving the accumulator guard bits; OUT_W = 2*DATA_W + ACC_GUARD.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port in1, input, LANES*DATA_W bits: operand A; lane i is bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port in2, input, LANES*DATA_W bits: operand B, packed like in1.
REQ-010 The block SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with the beat.
REQ-011 The block SHALL have port acc_en, input, 1 bit: 1 = add product to the lane accumulator, 0 = restart accumulator with product; sampled with the beat.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result beat present.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-014 The block SHALL have port out, output, LANES*OUT_W bits: results; lane i is bits [i*OUT_W +: OUT_W].

Function
REQ-015 A beat SHALL be accepted when in_valid && in_ready, and a result SHALL be consumed when out_valid && out_ready.
REQ-016 The pipeline SHALL have two register stages: stage 1 registers the per-lane 2*DATA_W product plus the is_signed/acc_en tags; stage 2 registers the accumulator/out. Fixed latency SHALL be 2 cycles from acceptance to out_valid when not stalled.
REQ-017 stall = out_valid && !out_ready; in_ready SHALL equal !stall (combinational); while stalled, both stages, the tags and out SHALL hold unchanged.
REQ-018 The product SHALL be sign-extended (is_signed=1) or zero-extended (is_signed=0) from 2*DATA_W to OUT_W bits before accumulation.
REQ-019 When stage 2 loads a valid beat: acc_en=1 gives acc[i] <= acc[i] + ext_prod[i]; acc_en=0 gives acc[i] <= ext_prod[i]; out lane i SHALL be the new acc[i].
REQ-020 Accumulation SHALL wrap modulo 2^OUT_W, with no saturation and no overflow flag.
REQ-021 Bubbles (stage-1 valid = 0) SHALL NOT modify acc; out_valid SHALL deassert after consumption when no beat follows.
REQ-022 Back-to-back beats SHALL sustain 1 beat/cycle while out_ready = 1.
REQ-023 Lanes SHALL be fully independent; is_signed/acc_en apply to all lanes of a beat.

Reset
REQ-024 When rst = 1 at a clock edge: stage valids, out_valid, out, all acc lanes and stage-1 data SHALL become 0; in-flight beats SHALL be discarded.
REQ-025 While rst = 1, in_ready SHALL be 1 (reset forces out_valid to 0) but accepted beats SHALL be dropped; the first valid beat after rst falls SHALL be treated normally.

Structure
REQ-026 The shared package vec_intmul_pkg SHALL hold the default parameter values and the OUT_W derivation.
REQ-027 One sub-module int_mul_lane (DATA_W, OUT_W; signed/unsigned multiply, extend, accumulate, one lane) SHALL be instantiated LANES times by a generate loop; the valid/stall control SHALL live in vec_intmul.

Verification (DATA_W=8, LANES=4, ACC_GUARD=4, OUT_W=20)
REQ-028 The bench SHALL drive unsigned lane0 255*255, acc_en=0 -> out lane0 = 0x0FE01 exactly 2 cycles after acceptance.
REQ-029 The bench SHALL drive signed lanes 0xFF*0x02 and 0x80*0x80, acc_en=0 -> 0xFFFFE and 0x04000; the same operands unsigned -> 0x001FE and 0x04000.
REQ-030 The bench SHALL drive 4 back-to-back unsigned 255*255 beats (acc_en 0,1,1,1) -> outs 0x0FE01, 0x1FC02, 0x2FA03, 0x3F804 on consecutive cycles; extending to 17 accumulating beats -> 0x0DE11 (wrap).
REQ-031 The bench SHALL hold out_ready low for 3 cycles while streaming -> in_ready low the same 3 cycles, out stable, no beat lost or duplicated, acc unchanged.
REQ-032 The bench SHALL assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid = 0, out = 0; a following acc_en=1 beat of 3*3 yields 9.

Source files
------------

// File: rtl/vec_intmul_pkg.sv
// ---------------------------------------------------------------------------
// vec_intmul_pkg
// Shared defaults for the vector integer multiply-accumulate block and the
// derivation of the per-lane result width.
//   DEF_DATA_W    : operand width per lane
//   DEF_LANES     : number of independent lanes
//   DEF_ACC_GUARD : accumulator guard bits above the full product width
//   calc_out_w()  : result width = 2*data_w + acc_guard
// ---------------------------------------------------------------------------
package vec_intmul_pkg;

    localparam int DEF_DATA_W    = 32'sd8;
    localparam int DEF_LANES     = 32'sd4;
    localparam int DEF_ACC_GUARD = 32'sd4;

    function automatic int calc_out_w(input int data_w, input int acc_guard);
        return (32'sd2 * data_w) + acc_guard;
    endfunction

    localparam int DEF_OUT_W = calc_out_w(DEF_DATA_W, DEF_ACC_GUARD);

endpackage

// File: rtl/vec_intmul_lane.sv
// ---------------------------------------------------------------------------
// int_mul_lane
// One multiply-accumulate lane. Stage 1 registers the full-width product of
// the presented operands; stage 2 extends that product to OUT_W bits and
// either restarts or adds into the lane accumulator (wrapping modulo 2^OUT_W).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   adv        : pipeline may advance this cycle (not stalled)
//   s1_valid   : stage 1 holds a live beat
//   is_signed  : signedness of the operands being presented
//   s1_signed  : signedness tag of the beat held in stage 1
//   s1_acc_en  : accumulate tag of the beat held in stage 1
//   a, b       : lane operands
//   acc        : registered lane accumulator (the lane result)
// ---------------------------------------------------------------------------
module int_mul_lane
    import vec_intmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              s1_valid,
    input  logic              is_signed,
    input  logic              s1_signed,
    input  logic              s1_acc_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [OUT_W-1:0]  acc
);

    localparam int PROD_W  = 2 * DATA_W;
    localparam int GUARD_W = OUT_W - PROD_W;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_r;
    logic [OUT_W-1:0]  ext_prod;
    logic [OUT_W-1:0]  acc_r;

    // Extend operands to the product width; the low PROD_W bits of the
    // extended product equal the signed (or unsigned) DATA_W x DATA_W product.
    always_comb begin
        a_ext = {PROD_W{1'b0}};
        b_ext = {PROD_W{1'b0}};
        if (is_signed) begin
            a_ext = {{DATA_W{a[DATA_W-1]}}, a};
            b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin
            a_ext = {{DATA_W{1'b0}}, a};
            b_ext = {{DATA_W{1'b0}}, b};
        end
        prod = a_ext * b_ext;
    end

    // Extend the stage-1 product into the guard bits using its own tag.
    always_comb begin
        ext_prod = {OUT_W{1'b0}};
        if (s1_signed) begin
            ext_prod = {{GUARD_W{prod_r[PROD_W-1]}}, prod_r};
        end else begin
            ext_prod = {{GUARD_W{1'b0}}, prod_r};
        end
    end

    // Stage 1: product register, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r <= {PROD_W{1'b0}};
        end else if (adv) begin
            prod_r <= prod;
        end else begin
            prod_r <= prod_r;
        end
    end

    // Stage 2: accumulator; bubbles and stalls leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {OUT_W{1'b0}};
        end else if (adv && s1_valid) begin
            if (s1_acc_en) begin
                acc_r <= acc_r + ext_prod;
            end else begin
                acc_r <= ext_prod;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/vec_intmul.sv
// ---------------------------------------------------------------------------
// vec_intmul
// LANES-wide integer multiply-accumulate with a two-stage valid/ready
// pipeline (fixed 2-cycle latency when not stalled, 1 beat/cycle).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : input handshake (in_ready is combinational)
//   in1, in2        : packed operands, lane i at [i*DATA_W +: DATA_W]
//   is_signed       : two's-complement operands for this beat
//   acc_en          : 1 = accumulate, 0 = restart accumulator
//   out_valid/ready : output handshake
//   out             : packed results, lane i at [i*OUT_W +: OUT_W]
// ---------------------------------------------------------------------------
module vec_intmul
    import vec_intmul_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LANES     = DEF_LANES,
    parameter int ACC_GUARD = DEF_ACC_GUARD,
    localparam int OUT_W    = calc_out_w(DATA_W, ACC_GUARD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in1,
    input  logic [LANES*DATA_W-1:0] in2,
    input  logic                    is_signed,
    input  logic                    acc_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out
);

    logic stall;
    logic adv;
    logic s1_valid_r;
    logic s1_signed_r;
    logic s1_acc_en_r;
    logic out_valid_r;

    // The whole pipeline freezes while a result waits on the consumer.
    assign stall     = out_valid_r && !out_ready;
    assign adv       = !stall;
    // During reset the output is being cleared, so the input side is open;
    // whatever is taken then is discarded by the reset itself.
    assign in_ready  = rst || !stall;
    assign out_valid = out_valid_r;

    // Stage valids and per-beat tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_signed_r <= 1'b0;
            s1_acc_en_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (adv) begin
            s1_valid_r  <= in_valid;
            s1_signed_r <= is_signed;
            s1_acc_en_r <= acc_en;
            out_valid_r <= s1_valid_r;
        end else begin
            s1_valid_r  <= s1_valid_r;
            s1_signed_r <= s1_signed_r;
            s1_acc_en_r <= s1_acc_en_r;
            out_valid_r <= out_valid_r;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        int_mul_lane #(
            .DATA_W (DATA_W),
            .OUT_W  (OUT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .s1_valid  (s1_valid_r),
            .is_signed (is_signed),
            .s1_signed (s1_signed_r),
            .s1_acc_en (s1_acc_en_r),
            .a         (in1[i*DATA_W +: DATA_W]),
            .b         (in2[i*DATA_W +: DATA_W]),
            .acc       (out[i*OUT_W +: OUT_W])
        );
    end

endmodule
